// File: rtl/dma_priority_arbiter_if.sv
// Request/grant bundle between the DMA arbiter and its neighbours.
// Covers DREQ conditioning inputs, CPU hold handshake and grant outputs.
interface dma_priority_arbiter_if;
  logic [3:0] DREQ;
  logic       dreqSenseLow;
  logic       priorityType;
  logic       controllerDisable;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic       HLDA;
  logic       serviceDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       grantValid;
  logic [7:0] priorityOrder;

  modport master (
    output DREQ, dreqSenseLow, priorityType,
    output controllerDisable, maskReg, requestReg,
    output HLDA, serviceDone,
    input  HRQ, DACK, activeChannel,
    input  grantValid, priorityOrder
  );

  modport slave (
    input  DREQ, dreqSenseLow, priorityType,
    input  controllerDisable, maskReg, requestReg,
    input  HLDA, serviceDone,
    output HRQ, DACK, activeChannel,
    output grantValid, priorityOrder
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 4-channel DMA request/priority stage: HRQ, fixed/rotating priority, DACK.
// Define DREQ_SYNC_EN to pass DREQ through a 2-flop synchroniser.
module dma_priority_arbiter #(
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] RESET_ORDER = 8'b11100100
) (
  input logic CLK,
  input logic RESET,
  dma_priority_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    REQ   = 3'b010,
    GRANT = 3'b100
  } state_t;

  localparam int I_IDLE  = 0;
  localparam int I_REQ   = 1;
  localparam int I_GRANT = 2;

  state_t     state, state_n;
  logic       hrq_q, hrq_n;
  logic [3:0] dack_q, dack_n;
  logic [1:0] act_q, act_n;
  logic       gv_q, gv_n;
  logic [7:0] order_q, order_n;

  logic [3:0] dreq;
  logic [3:0] eff;
  logic       any;
  logic [1:0] win;

`ifdef DREQ_SYNC_EN
  logic [3:0] sync1, sync2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.DREQ;
      sync2 <= sync1;
    end
  end

  assign dreq = sync2;
`else
  assign dreq = bus.DREQ;
`endif

  // Software requests bypass both the mask and the pin polarity.
  assign eff = ((dreq ^ {4{bus.dreqSenseLow}}) & ~bus.maskReg)
             | bus.requestReg;
  assign any = |eff;

  // Scan lowest-priority slot first so slot0 overrides.
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eff[order_q[2*i +: 2]]) win = order_q[2*i +: 2];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      hrq_q   <= 1'b0;
      dack_q  <= '0;
      act_q   <= '0;
      gv_q    <= 1'b0;
      order_q <= RESET_ORDER;
    end else begin
      state   <= state_n;
      hrq_q   <= hrq_n;
      dack_q  <= dack_n;
      act_q   <= act_n;
      gv_q    <= gv_n;
      order_q <= order_n;
    end
  end

  always_comb begin
    state_n = state;
    hrq_n   = hrq_q;
    dack_n  = dack_q;
    act_n   = act_q;
    gv_n    = gv_q;
    order_n = order_q;
    unique case (1'b1)
      state[I_IDLE]: begin
        if (any && !bus.controllerDisable) begin
          state_n = REQ;
          hrq_n   = 1'b1;
        end
      end
      state[I_REQ]: begin
        if (bus.HLDA && any) begin
          state_n = GRANT;
          dack_n  = 4'b0001 << win;
          act_n   = win;
          gv_n    = 1'b1;
        end else if (!any || bus.controllerDisable) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
        end
      end
      state[I_GRANT]: begin
        if (bus.serviceDone || !bus.HLDA) begin
          state_n = IDLE;
          hrq_n   = 1'b0;
          dack_n  = '0;
          gv_n    = 1'b0;
        end
        // Served channel drops to the lowest slot.
        if (bus.serviceDone) begin
          order_n = bus.priorityType
                  ? {act_q, act_q + 2'd3, act_q + 2'd2, act_q + 2'd1}
                  : RESET_ORDER;
        end
      end
      default: begin
        state_n = IDLE;
        hrq_n   = 1'b0;
        dack_n  = '0;
        gv_n    = 1'b0;
      end
    endcase
  end

  assign bus.HRQ           = hrq_q;
  assign bus.DACK          = dack_q;
  assign bus.activeChannel = act_q;
  assign bus.grantValid    = gv_q;
  assign bus.priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios plus random traffic
// checked every cycle against a list-based priority model.
module tb_dma_priority_arbiter;

  logic CLK = 1'b0;
  logic RESET;

  dma_priority_arbiter_if bus ();

  dma_priority_arbiter dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  int         ord[4];
  bit         m_hrq;
  bit         m_gv;
  bit [3:0]   m_dack;
  bit [1:0]   m_act;
  bit [3:0]   m_s1, m_s2;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pack_ord();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) p[2*i +: 2] = 2'(ord[i]);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ord[i] = i;
    m_hrq  = 0;
    m_gv   = 0;
    m_dack = '0;
    m_act  = '0;
    m_s1   = '0;
    m_s2   = '0;
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_edge();
    bit [3:0] dq, eff;
    int       w;
    int       a;
`ifdef DREQ_SYNC_EN
    dq   = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.DREQ;
`else
    dq = bus.DREQ;
`endif
    eff = ((dq ^ {4{bus.dreqSenseLow}}) & ~bus.maskReg) | bus.requestReg;
    w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && eff[ord[i]]) w = ord[i];
    if (m_gv) begin
      if (bus.serviceDone) begin
        a = m_act;
        for (int i = 0; i < 4; i++)
          ord[i] = bus.priorityType ? (a + 1 + i) % 4 : i;
      end
      if (bus.serviceDone || !bus.HLDA) begin
        m_gv   = 0;
        m_hrq  = 0;
        m_dack = '0;
      end
    end else if (m_hrq) begin
      if (bus.HLDA && w >= 0) begin
        m_gv   = 1;
        m_act  = 2'(w);
        m_dack = 4'(1 << w);
      end else if (w < 0 || bus.controllerDisable) begin
        m_hrq = 0;
      end
    end else if (w >= 0 && !bus.controllerDisable) begin
      m_hrq = 1;
    end
  endtask

  task automatic check_all();
    chk("hrq", bus.HRQ, m_hrq);
    chk("dack", bus.DACK, m_dack);
    chk("gv", bus.grantValid, m_gv);
    if (m_gv) chk("act", bus.activeChannel, m_act);
    chk("order", bus.priorityOrder, pack_ord());
    chk("onehot", $onehot0(bus.DACK), 1);
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.DREQ              = '0;
    bus.dreqSenseLow      = 0;
    bus.priorityType      = 0;
    bus.controllerDisable = 0;
    bus.maskReg           = '0;
    bus.requestReg        = '0;
    bus.HLDA              = 0;
    bus.serviceDone       = 0;
  endtask

  initial begin
    idle_inputs();
    RESET = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 0;
    chk("rst_hrq", bus.HRQ, 0);
    chk("rst_dack", bus.DACK, 4'b0000);
    chk("rst_order", bus.priorityOrder, 8'hE4);
    check_all();

    // fixed priority, ch1 wins over 2 and 3
    bus.DREQ = 4'b1110;
    step();
    chk("fix_hrq", bus.HRQ, 1);
    step();
    bus.HLDA = 1;
    step();
    chk("fix_dack", bus.DACK, 4'b0010);
    bus.serviceDone = 1;
    step();
    bus.serviceDone = 0;
    bus.HLDA = 0;
    bus.DREQ = '0;
    chk("fix_rel", bus.DACK, 4'b0000);
    chk("fix_order", bus.priorityOrder, 8'hE4);
    step();

    // rotating priority
    bus.priorityType = 1;
    bus.DREQ = 4'b1111;
    step();
    bus.HLDA = 1;
    step();
    chk("rot_dack0", bus.DACK, 4'b0001);
    bus.serviceDone = 1;
    step();
    bus.serviceDone = 0;
    bus.HLDA = 0;
    chk("rot_order0", bus.priorityOrder, 8'b00_11_10_01);
    step();
    bus.HLDA = 1;
    step();
    chk("rot_dack1", bus.DACK, 4'b0010);
    bus.serviceDone = 1;
    step();
    bus.serviceDone = 0;
    bus.HLDA = 0;
    bus.DREQ = '0;
    chk("rot_order1", bus.priorityOrder, 8'b01_00_11_10);
    step();

    // mask blocks DREQ; software request bypasses it
    bus.priorityType = 0;
    bus.maskReg = 4'b0001;
    bus.DREQ = 4'b0001;
    step();
    step();
    chk("mask_hrq", bus.HRQ, 0);
    bus.requestReg = 4'b0001;
    step();
    chk("sw_hrq", bus.HRQ, 1);
    bus.HLDA = 1;
    step();
    chk("sw_dack", bus.DACK, 4'b0001);
    bus.serviceDone = 1;
    step();
    idle_inputs();
    step();

    // active-low DREQ and CPU abort
    bus.dreqSenseLow = 1;
    bus.DREQ = 4'b1011;
    step();
    bus.HLDA = 1;
    step();
    chk("pol_dack", bus.DACK, 4'b0100);
    bus.HLDA = 0;
    bus.DREQ = 4'b1111;
    step();
    chk("abort_dack", bus.DACK, 4'b0000);
    chk("abort_hrq", bus.HRQ, 0);
    chk("abort_order", bus.priorityOrder, 8'hE4);
    idle_inputs();
    step();

    // request withdrawn before HLDA
    bus.DREQ = 4'b0100;
    step();
    chk("wd_hrq1", bus.HRQ, 1);
    bus.DREQ = '0;
    step();
    chk("wd_hrq0", bus.HRQ, 0);
    bus.HLDA = 1;
    step();
    chk("wd_dack", bus.DACK, 4'b0000);
    idle_inputs();
    step();

    // async reset in the middle of a grant
    bus.priorityType = 1;
    bus.DREQ = 4'b0100;
    step();
    bus.HLDA = 1;
    step();
    chk("ar_dack", bus.DACK, 4'b0100);
    #2;
    RESET = 1;
    #1;
    chk("ar_dack0", bus.DACK, 4'b0000);
    chk("ar_hrq0", bus.HRQ, 0);
    chk("ar_order", bus.priorityOrder, 8'hE4);
    model_reset();
    idle_inputs();
    @(negedge CLK);
    RESET = 0;
    step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      bus.DREQ              = 4'($urandom);
      bus.maskReg           = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      bus.requestReg        = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      bus.controllerDisable = ($urandom_range(0, 9) == 0);
      bus.serviceDone       = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 49) == 0) bus.priorityType = ~bus.priorityType;
      if ($urandom_range(0, 99) == 0) bus.dreqSenseLow = ~bus.dreqSenseLow;
      if (m_gv)       bus.HLDA = ($urandom_range(0, 19) != 0);
      else if (m_hrq) bus.HLDA = ($urandom_range(0, 2) != 0);
      else            bus.HLDA = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
